// File: rtl/conv_anchor_ctrl.sv
// Convolution anchor sequencer: walks the output grid one window at a time,
// steps the kernel anchor, waits for the MAC result and hands it downstream.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   start             begin a layer (honoured only while idle)
//   abort             cancel the layer, back to idle next cycle
//   mac_valid         mac_result for the current window is ready
//   mac_result        MAC result word
//   result_ready      downstream accepts result_data/result_addr
//   conv_en           window-buffer enable (low clears the buffer)
//   archor_2D         window row anchor
//   archor_1D         window column anchor
//   result_valid      result_data/result_addr valid
//   result_data       captured MAC result
//   result_addr       linear output index row*result_length+col
//   busy              layer in progress
//   done              one-cycle completion pulse

module conv_anchor_ctrl #(
  parameter int data_width    = 16,
  parameter int image_length  = 4,
  parameter int image_width   = 4,
  parameter int weight_length = 3,
  parameter int weight_width  = 3,
  parameter int stride        = 1,
  parameter int result_length = 2,
  parameter int result_width  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mac_valid,
  input  logic [data_width-1:0] mac_result,
  input  logic                  result_ready,
  output logic                  conv_en,
  output logic [data_width-1:0] archor_2D,
  output logic [data_width-1:0] archor_1D,
  output logic                  result_valid,
  output logic [data_width-1:0] result_data,
  output logic [15:0]           result_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Largest anchor that still keeps the kernel inside the image.
  localparam int RowMax =
    (image_width > weight_width) ? image_width - weight_width : 0;
  localparam int ColMax =
    (image_length > weight_length) ? image_length - weight_length : 0;

  localparam logic [15:0] LastRow = 16'(result_width - 1);
  localparam logic [15:0] LastCol = 16'(result_length - 1);

  state_t state_q, state_d;

  logic [15:0]           row_q, row_d;
  logic [15:0]           col_q, col_d;
  logic                  conv_en_q, conv_en_d;
  logic [data_width-1:0] a2d_q, a2d_d;
  logic [data_width-1:0] a1d_q, a1d_d;
  logic                  rvalid_q, rvalid_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic [15:0]           raddr_q, raddr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Anchor = index*stride, saturated at the image edge so a
  // mis-sized parameter set can never address outside the image.
  function automatic logic [data_width-1:0] anchor(
    input logic [15:0] idx,
    input int          lim
  );
    logic [31:0] p;
    p = 32'(idx) * 32'(stride);
    if (p > 32'(lim)) begin
      p = 32'(lim);
    end
    return data_width'(p);
  endfunction

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    conv_en_d = 1'b0;
    a2d_d     = a2d_q;
    a1d_d     = a1d_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    // Outputs are registered, so each branch drives the values
    // belonging to the state being entered.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      a2d_d   = '0;
      a1d_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            row_d     = '0;
            col_d     = '0;
            conv_en_d = 1'b1;
            busy_d    = 1'b1;
            a2d_d     = '0;
            a1d_d     = '0;
          end
        end
        S_LOAD: begin
          state_d   = S_WAIT;
          conv_en_d = 1'b1;
          busy_d    = 1'b1;
        end
        S_WAIT: begin
          busy_d = 1'b1;
          if (mac_valid) begin
            state_d  = S_EMIT;
            rvalid_d = 1'b1;
            rdata_d  = mac_result;
            raddr_d  = 16'(32'(row_q) * 32'(result_length)
                         + 32'(col_q));
          end else begin
            conv_en_d = 1'b1;
          end
        end
        S_EMIT: begin
          busy_d = 1'b1;
          if (result_ready) begin
            state_d = S_NEXT;
          end else begin
            rvalid_d = 1'b1;
          end
        end
        S_NEXT: begin
          if (row_q == LastRow && col_q == LastCol) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else begin
            if (col_q == LastCol) begin
              col_d = '0;
              row_d = row_q + 16'd1;
            end else begin
              col_d = col_q + 16'd1;
            end
            state_d   = S_LOAD;
            conv_en_d = 1'b1;
            busy_d    = 1'b1;
            a2d_d     = anchor(row_d, RowMax);
            a1d_d     = anchor(col_d, ColMax);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      conv_en_q <= 1'b0;
      a2d_q     <= '0;
      a1d_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      conv_en_q <= conv_en_d;
      a2d_q     <= a2d_d;
      a1d_q     <= a1d_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign conv_en      = conv_en_q;
  assign archor_2D    = a2d_q;
  assign archor_1D    = a1d_q;
  assign result_valid = rvalid_q;
  assign result_data  = rdata_q;
  assign result_addr  = raddr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_anchor_ctrl.sv
// Bench for conv_anchor_ctrl: two instances (stride 1 on 4x4, stride 2 on
// 5x5) share stimulus; expected windows come from a grid-walk model.

module tb_conv_anchor_ctrl;

  localparam int DW = 16;
  localparam int RL = 2;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort, mac_valid, result_ready;
  logic [DW-1:0] mac_result;

  logic          ce_a, rv_a, busy_a, done_a;
  logic [DW-1:0] r2_a, c1_a, rd_a;
  logic [15:0]   ra_a;
  logic          ce_b, rv_b, busy_b, done_b;
  logic [DW-1:0] r2_b, c1_b, rd_b;
  logic [15:0]   ra_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  conv_anchor_ctrl u_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mac_valid(mac_valid), .mac_result(mac_result),
    .result_ready(result_ready), .conv_en(ce_a),
    .archor_2D(r2_a), .archor_1D(c1_a), .result_valid(rv_a),
    .result_data(rd_a), .result_addr(ra_a), .busy(busy_a),
    .done(done_a)
  );

  conv_anchor_ctrl #(
    .image_length(5), .image_width(5), .stride(2)
  ) u_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mac_valid(mac_valid), .mac_result(mac_result),
    .result_ready(result_ready), .conv_en(ce_b),
    .archor_2D(r2_b), .archor_1D(c1_b), .result_valid(rv_b),
    .result_data(rd_b), .result_addr(ra_b), .busy(busy_b),
    .done(done_b)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    mac_valid = 1'b0; mac_result = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ce_a, r2_a, c1_a, rv_a, rd_a, ra_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got ce=%b r=%0d c=%0d rv=%b d=%h a=%0d bz=%b dn=%b want all 0",
               ce_a, r2_a, c1_a, rv_a, rd_a, ra_a, busy_a, done_a);
    end
    vectors++;
    if ({ce_b, r2_b, c1_b, rv_b, rd_b, ra_b, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got ce=%b r=%0d c=%0d rv=%b bz=%b dn=%b want all 0",
               ce_b, r2_b, c1_b, rv_b, busy_b, done_b);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0 || ce_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got bz=%b ce=%b dn=%b want 0 0 0",
               busy_a, ce_a, done_a);
    end
  endtask

  // One full layer. kfix>0 fixes mac latency, stallfix>=0 fixes the
  // downstream stall, tbl selects the fixed result table.
  task automatic test_layer(input int kfix, input int stallfix,
                            input bit tbl);
    logic [15:0] tab [NW];
    logic [15:0] d;
    int k, st, r, c;
    tab = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      r  = w / RL;
      c  = w % RL;
      k  = (kfix > 0) ? kfix : $urandom_range(1, 4);
      st = (stallfix >= 0) ? stallfix : $urandom_range(0, 3);
      d  = tbl ? tab[w] : 16'($urandom);
      vectors++;
      if (ce_a !== 1'b1 || busy_a !== 1'b1 || r2_a !== DW'(r) ||
          c1_a !== DW'(c)) begin
        errors++;
        $display("FAIL load_a w%0d: got ce=%b bz=%b (%0d,%0d) want 1 1 (%0d,%0d)",
                 w, ce_a, busy_a, r2_a, c1_a, r, c);
      end
      vectors++;
      if (ce_b !== 1'b1 || r2_b !== DW'(2 * r) ||
          c1_b !== DW'(2 * c)) begin
        errors++;
        $display("FAIL load_b w%0d: got ce=%b (%0d,%0d) want 1 (%0d,%0d)",
                 w, ce_b, r2_b, c1_b, 2 * r, 2 * c);
      end
      mac_valid  = 1'($urandom_range(0, 1));
      mac_result = 16'($urandom);
      for (int i = 1; i <= k; i++) begin
        @(negedge clk);
        vectors++;
        if (ce_a !== 1'b1 || rv_a !== 1'b0 || busy_a !== 1'b1 ||
            r2_a !== DW'(r) || c1_a !== DW'(c)) begin
          errors++;
          $display("FAIL wait_a w%0d: got ce=%b rv=%b bz=%b (%0d,%0d) want 1 0 1 (%0d,%0d)",
                   w, ce_a, rv_a, busy_a, r2_a, c1_a, r, c);
        end
        mac_valid    = (i == k);
        mac_result   = (i == k) ? d : 16'($urandom);
        start        = (i < k) ? 1'($urandom_range(0, 1)) : 1'b0;
        result_ready = (i == k) && (st == 0);
      end
      @(negedge clk);
      mac_valid = 1'b0;
      start     = 1'b0;
      vectors++;
      if (rv_a !== 1'b1 || rd_a !== d || ra_a !== 16'(w) ||
          ce_a !== 1'b0 || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL emit_a w%0d: got rv=%b d=%h a=%0d ce=%b want 1 %h %0d 0",
                 w, rv_a, rd_a, ra_a, ce_a, d, w);
      end
      vectors++;
      if (rv_b !== 1'b1 || rd_b !== d || ra_b !== 16'(w)) begin
        errors++;
        $display("FAIL emit_b w%0d: got rv=%b d=%h a=%0d want 1 %h %0d",
                 w, rv_b, rd_b, ra_b, d, w);
      end
      for (int s = 1; s <= st; s++) begin
        @(negedge clk);
        vectors++;
        if (rv_a !== 1'b1 || rd_a !== d || ra_a !== 16'(w) ||
            ce_a !== 1'b0 || r2_a !== DW'(r) || c1_a !== DW'(c)) begin
          errors++;
          $display("FAIL stall_a w%0d s%0d: got rv=%b d=%h a=%0d ce=%b want 1 %h %0d 0",
                   w, s, rv_a, rd_a, ra_a, ce_a, d, w);
        end
        if (s == st) result_ready = 1'b1;
      end
      @(negedge clk);
      result_ready = 1'b0;
      vectors++;
      if (rv_a !== 1'b0 || ce_a !== 1'b0 || busy_a !== 1'b1 ||
          done_a !== 1'b0) begin
        errors++;
        $display("FAIL next_a w%0d: got rv=%b ce=%b bz=%b dn=%b want 0 0 1 0",
                 w, rv_a, ce_a, busy_a, done_a);
      end
      @(negedge clk);
    end
    vectors++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || ce_a !== 1'b0 ||
        done_b !== 1'b1) begin
      errors++;
      $display("FAIL done: got dn=%b bz=%b ce=%b dn_b=%b want 1 0 0 1",
               done_a, busy_a, ce_a, done_b);
    end
    @(negedge clk);
    vectors++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got dn=%b bz=%b dn_b=%b want 0 0 0",
               done_a, busy_a, done_b);
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mac_valid = 1'b1; mac_result = 16'h1234; result_ready = 1'b1;
    @(negedge clk);
    mac_valid = 1'b0;
    @(negedge clk);
    result_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (ce_a !== 1'b1 || r2_a !== DW'(0) || c1_a !== DW'(1)) begin
      errors++;
      $display("FAIL abort_load2: got ce=%b (%0d,%0d) want 1 (0,1)",
               ce_a, r2_a, c1_a);
    end
    @(negedge clk);
    mac_valid = 1'b1; abort = 1'b1; result_ready = 1'b1;
    mac_result = 16'hBEEF;
    @(negedge clk);
    mac_valid = 1'b0; abort = 1'b0; result_ready = 1'b0;
    vectors++;
    if (ce_a !== 1'b0 || busy_a !== 1'b0 || rv_a !== 1'b0 ||
        done_a !== 1'b0 || r2_a !== '0 || c1_a !== '0) begin
      errors++;
      $display("FAIL abort_idle: got ce=%b bz=%b rv=%b dn=%b (%0d,%0d) want 0 0 0 0 (0,0)",
               ce_a, busy_a, rv_a, done_a, r2_a, c1_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (rv_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0 ||
          done_b !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet c%0d: got rv=%b dn=%b bz=%b want 0 0 0",
                 i, rv_a, done_a, busy_a);
      end
    end
    test_layer(0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mac_valid = 1'b1; mac_result = 16'h5A5A; result_ready = 1'b0;
    @(negedge clk);
    mac_valid = 1'b0;
    vectors++;
    if (rv_a !== 1'b1 || rd_a !== 16'h5A5A) begin
      errors++;
      $display("FAIL rst_emit: got rv=%b d=%h want 1 5a5a", rv_a, rd_a);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({ce_a, r2_a, c1_a, rv_a, rd_a, ra_a, busy_a, done_a} !== '0 ||
        {ce_b, rv_b, rd_b, busy_b} !== '0) begin
      errors++;
      $display("FAIL rst_async: got rv=%b d=%h bz=%b rv_b=%b want 0 0 0 0",
               rv_a, rd_a, busy_a, rv_b);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_layer(0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_layer(2, 0, 1'b1);
    for (int n = 0; n < 4; n++) test_layer(0, -1, 1'b0);
    test_layer(2, 5, 1'b0);
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/conv_anchor_ctrl.md
CONV_ANCHOR_CTRL -- requirements
Module: conv_anchor_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): data_width, 16, result word width; image_length, 4, image columns; image_width, 4, image rows; weight_length, 3, kernel columns; weight_width, 3, kernel rows; stride, 1, anchor step; result_length, 2, output columns; result_width, 2, output rows.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports (name direction width meaning):
- clk in 1: clock
- reset in 1: async active-high reset
- start in 1: start-of-layer pulse
- abort in 1: synchronous cancel
- mac_valid in 1: MAC result for current window ready
- mac_result in data_width: MAC result
- result_ready in 1: downstream accepts result
- conv_en out 1: window-buffer enable
- archor_2D out data_width: window row anchor
- archor_1D out data_width: window column anchor
- result_valid out 1: result_data/result_addr valid
- result_data out data_width: captured MAC result
- result_addr out 16: linear output index
- busy out 1: layer in progress
- done out 1: one-cycle completion pulse

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, WAIT, EMIT, NEXT, DONE; all outputs registered.
REQ-005 IDLE: busy=0, conv_en=0; start=1 -> LOAD with row=0, col=0; start ignored in all other states.
REQ-006 LOAD: conv_en=1, anchors = row*stride, col*stride; lasts exactly 1 cycle -> WAIT.
REQ-007 WAIT: conv_en held 1, anchors held; on mac_valid=1 capture mac_result into result_data -> EMIT; mac_valid outside WAIT ignored.
REQ-008 EMIT: result_valid=1, result_addr = row*result_length + col; result_data/result_addr stable until result_ready=1 sampled; then result_valid=0 -> NEXT.
REQ-009 EMIT with result_ready already 1 on entry: result_valid high exactly 1 cycle.
REQ-010 NEXT: conv_en=0 for 1 cycle (clears window buffer); col increments; col wraps to 0 at result_length-1 and row increments; after row=result_width-1, col=result_length-1 -> DONE, else -> LOAD.
REQ-011 DONE: done=1 for exactly 1 cycle, busy=0 -> IDLE.
REQ-012 busy SHALL be 1 in LOAD, WAIT, EMIT, NEXT.
REQ-013 abort=1 in any non-IDLE state -> IDLE next cycle: conv_en=0, result_valid=0, counters 0, no done pulse; abort wins over simultaneous mac_valid or result_ready.
REQ-014 Row/col counters SHALL be 16 bits; anchors zero-extended to data_width; anchor product SHALL NOT exceed image bounds for parameters satisfying (result-1)*stride+weight <= image dimension.
REQ-015 Per-window latency, start to first result_valid with mac_valid returned k cycles after LOAD: k+2 cycles.

Reset
REQ-016 reset=1 SHALL asynchronously force IDLE, row=col=0, conv_en=0, archor_2D=archor_1D=0, result_valid=0, result_data=0, result_addr=0, busy=0, done=0.
REQ-017 Reset mid-layer SHALL discard the pending window; the first start after release begins at anchor (0,0).

Verification
REQ-018 Defaults, start, mac_valid 2 cycles after each LOAD with results 0x3C00,0x4000,0x4200,0x4400, result_ready=1 -> anchors (0,0),(0,1),(1,0),(1,1); result_addr 0..3 with matching data; single done pulse.
REQ-019 image 5x5, weight 3x3, stride 2, result 2x2 -> archor pairs (0,0),(0,2),(2,0),(2,2).
REQ-020 result_ready held 0 for 5 cycles in EMIT -> result_valid, data, addr stable 5 cycles; conv_en 0, no anchor advance.
REQ-021 abort asserted in WAIT of window 2 with mac_valid=1 -> IDLE next cycle, no result_valid, no done; subsequent start restarts at (0,0).
REQ-022 reset asserted during EMIT -> all outputs zero same cycle (asynchronous); start pulse during busy -> ignored, sequence unchanged.
